// File: rtl/pc_sequencer_if.sv
// Program-counter sequencer bus: control requests and targets toward the
// sequencer, current address and stack status back from it.
interface pc_sequencer_if #(
    parameter int AW = 8,
    parameter int SD = 4
);
    localparam int DW = $clog2(SD) + 1;

    logic          en;
    logic          jump;
    logic          call;
    logic          ret;
    logic          branch;
    logic [AW-1:0] t_addr;
    logic [AW-1:0] b_off;
    logic [AW-1:0] addr;
    logic [DW-1:0] depth;
    logic          ovf;
    logic          unf;

    // Sequencer side
    modport slave (
        input  en,
        input  jump,
        input  call,
        input  ret,
        input  branch,
        input  t_addr,
        input  b_off,
        output addr,
        output depth,
        output ovf,
        output unf
    );

    // Controller side
    modport master (
        output en,
        output jump,
        output call,
        output ret,
        output branch,
        output t_addr,
        output b_off,
        input  addr,
        input  depth,
        input  ovf,
        input  unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with return stack.
// Fixed request priority: jump > call > ret > branch > increment.
// Only the winning request has any effect; stalled cycles (en=0) hold all
// state. ovf/unf are sticky until the asynchronous active-low reset.
module pc_sequencer #(
    parameter int AW = 8,
    parameter int SD = 4
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.slave   bus
);
    localparam int DW = $clog2(SD) + 1;
    localparam int IW = $clog2(SD);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          unf_q;
    logic          unf_d;

    // Return stack; contents are don't-care above depth, so no reset needed.
    logic [AW-1:0] stack_q [SD];

    logic          push_s;
    logic          full_s;
    logic          empty_s;
    logic [IW-1:0] push_idx_s;
    logic [IW-1:0] top_idx_s;
    logic [AW-1:0] top_s;
    logic [AW-1:0] addr_inc_s;
    logic [AW-1:0] addr_br_s;

    // Sequential address and modular arithmetic helpers
    assign addr_inc_s = addr_q + AW'(1);
    assign addr_br_s  = addr_q + bus.b_off;
    assign full_s     = (depth_q == DW'(SD));
    assign empty_s    = (depth_q == DW'(0));
    // Next free slot is at index depth; top of stack is one below it.
    assign push_idx_s = depth_q[IW-1:0];
    assign top_idx_s  = push_idx_s - IW'(1);
    assign top_s      = stack_q[top_idx_s];

    // Next-state selection by fixed request priority
    always_comb begin
        addr_d  = addr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_s  = 1'b0;
        if (bus.en) begin
            if (bus.jump) begin
                addr_d = bus.t_addr;
            end else if (bus.call) begin
                if (!full_s) begin
                    push_s  = 1'b1;
                    depth_d = depth_q + DW'(1);
                    addr_d  = bus.t_addr;
                end else begin
                    ovf_d  = 1'b1;
                    addr_d = addr_inc_s;
                end
            end else if (bus.ret) begin
                if (!empty_s) begin
                    addr_d  = top_s;
                    depth_d = depth_q - DW'(1);
                end else begin
                    unf_d  = 1'b1;
                    addr_d = addr_inc_s;
                end
            end else if (bus.branch) begin
                addr_d = addr_br_s;
            end else begin
                addr_d = addr_inc_s;
            end
        end else begin
            addr_d  = addr_q;
            depth_d = depth_q;
        end
    end

    // Architectural state register with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= AW'(0);
            depth_q <= DW'(0);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-stack write: store the return address on a successful call
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_q[push_idx_s] <= addr_inc_s;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.depth = depth_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning address width in bits (range 4..16).
REQ-002 The block SHALL have parameter SD, default 4, meaning return-stack depth in entries (power of two, 2..16).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port en  input  1  advance enable; 0 = stall, all state held.
REQ-006 The block SHALL have port jump  input  1  absolute jump request.
REQ-007 The block SHALL have port call  input  1  subroutine call request (push + jump).
REQ-008 The block SHALL have port ret  input  1  subroutine return request (pop).
REQ-009 The block SHALL have port branch  input  1  PC-relative branch request.
REQ-010 The block SHALL have port t_addr  input  AW  absolute target for jump/call.
REQ-011 The block SHALL have port b_off  input  AW  two's-complement branch offset.
REQ-012 The block SHALL have port addr  output  AW  current program address, registered.
REQ-013 The block SHALL have port depth  output  clog2(SD)+1  current stack occupancy, 0..SD.
REQ-014 The block SHALL have port ovf  output  1  sticky flag: call attempted with stack full.
REQ-015 The block SHALL have port unf  output  1  sticky flag: ret attempted with stack empty.

Function
REQ-016 The block SHALL act only on rising clk edges with en=1; with en=0 addr, stack, depth, ovf, unf SHALL hold regardless of other inputs.
REQ-017 The block SHALL resolve simultaneous requests by fixed priority jump > call > ret > branch > increment; lower-priority requests in the same cycle SHALL be ignored entirely (no push/pop side effects).
REQ-018 The block SHALL, on jump, load addr <= t_addr next cycle; stack unchanged.
REQ-019 The block SHALL, on call with depth<SD, push addr+1 (mod 2^AW) to the stack top, increment depth, and load addr <= t_addr.
REQ-020 The block SHALL, on call with depth==SD, leave stack and depth unchanged, set ovf, and load addr <= addr+1.
REQ-021 The block SHALL, on ret with depth>0, load addr <= stack top, pop it, and decrement depth.
REQ-022 The block SHALL, on ret with depth==0, leave depth at 0, set unf, and load addr <= addr+1.
REQ-023 The block SHALL, on branch, load addr <= addr + b_off, truncated to AW bits (wraps both directions).
REQ-024 The block SHALL, with en=1 and no request, load addr <= addr+1; 2^AW-1 SHALL wrap to 0.
REQ-025 The block SHALL have single-cycle latency: a request sampled at edge N is visible on addr after edge N.
REQ-026 The block SHALL, once set, hold ovf and unf at 1 until reset; no other clear path.
REQ-027 The block SHALL store stack entries in a register array indexed by depth (LIFO); entries above depth are don't-care and never visible.

Reset
REQ-028 The block SHALL, on rst=0, immediately (asynchronously) force addr=0, depth=0, ovf=0, unf=0, including mid-operation.
REQ-029 The block SHALL not require stack-array contents to be cleared by reset.
REQ-030 The block SHALL resume normal operation on the first rising clk edge after rst returns to 1 (first update: addr 0 -> 1 if en=1, no request).

Verification (AW=8, SD=4)
REQ-031 Bench SHALL cover: reset release, en=1 for 3 cycles -> addr 0,1,2,3; en=0 for 2 cycles -> addr holds 3.
REQ-032 Bench SHALL cover: addr=0xFE, increment twice -> 0xFF, 0x00; at addr=0x02, branch b_off=0xFC -> addr=0xFE.
REQ-033 Bench SHALL cover: at addr=0x10, call t_addr=0x40 -> addr=0x40, depth=1; then ret -> addr=0x11, depth=0.
REQ-034 Bench SHALL cover: 4 nested calls -> depth=4; 5th call at addr=0x20 -> addr=0x21, depth=4, ovf=1; 4 rets return addresses in reverse order; 5th ret -> unf=1, addr increments.
REQ-035 Bench SHALL cover: jump+call+branch asserted together with t_addr=0x80 -> addr=0x80, depth unchanged; call+ret together -> call wins, depth+1.
REQ-036 Bench SHALL cover: rst asserted between clock edges with depth=3, ovf=1 -> addr=0, depth=0, ovf=0 immediately without a clk edge.
